// File: rtl/mem_access_unit.sv
// mem_access_unit: data-memory stage of the multi-cycle core.
// Performs byte/half/word loads and stores to the data BRAM or the MMIO bus,
// with lane alignment, sign/zero extension, MMIO handshake and timeout.
// Optional build macro: MEM_MISALIGN_TRAP_EN. When it is defined, misaligned
// accesses are flagged and suppressed. When it is not defined, misaligned
// addresses are masked to natural alignment.
module mem_access_unit #(
    parameter int          ADDR_W       = 15,
    parameter logic [15:0] MMIO_HI      = 16'h8000,
    parameter int          MMIO_TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              mem_start,
    input  logic              op_load,
    input  logic              op_store,
    input  logic [2:0]        funct3,
    input  logic [31:0]       addr,
    input  logic [31:0]       store_data,
    output logic [ADDR_W-1:0] bram_addr,
    output logic [3:0]        bram_we,
    output logic [31:0]       bram_wdata,
    input  logic [31:0]       bram_rdata,
    output logic              mmio_valid,
    output logic              mmio_we,
    output logic [31:0]       mmio_addr,
    output logic [31:0]       mmio_wdata,
    input  logic              mmio_ready,
    input  logic [31:0]       mmio_rdata,
    output logic [31:0]       load_data,
    output logic              mem_busy,
    output logic              misaligned,
    output logic              bus_err
);

`ifdef MEM_MISALIGN_TRAP_EN
    localparam logic TRAP_EN = 1'b1;
`else
    localparam logic TRAP_EN = 1'b0;
`endif

    localparam int                CNT_W       = $clog2(MMIO_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LIM = CNT_W'(MMIO_TIMEOUT);

    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_BRAM_RD  = 2'd1;
    localparam logic [1:0] S_MMIO_REQ = 2'd2;
    localparam logic [1:0] S_DONE     = 2'd3;

    logic [1:0]        state;
    logic [ADDR_W-1:0] waddr_p0;
    logic [1:0]        lane_p0;
    logic [2:0]        funct3_p0;
    logic              load_p0;
    logic [CNT_W-1:0]  tmo_cnt;
    logic [CNT_W-1:0]  tmo_nxt;

    logic              req_mmio;
    logic              req_store;
    logic              req_load;
    logic              req_trap;
    logic [31:0]       addr_eff;
    logic              bram_go;

    // Lane-replicated store data: byte x4, half x2, word as is.
    function automatic logic [31:0] replicate(input logic [1:0] sz, input logic [31:0] d);
        case (sz)
            2'b00:   replicate = {4{d[7:0]}};
            2'b01:   replicate = {2{d[15:0]}};
            default: replicate = d;
        endcase
    endfunction

    // Byte write enables for an access of the given size and lane.
    function automatic logic [3:0] byte_en(input logic [1:0] sz, input logic [1:0] lane);
        case (sz)
            2'b00:   byte_en = 4'b0001 << lane;
            2'b01:   byte_en = 4'b0011 << {lane[1], 1'b0};
            2'b10:   byte_en = 4'b1111;
            default: byte_en = 4'b0000;
        endcase
    endfunction

    // Halfword on an odd address or word off a 4-byte boundary.
    function automatic logic misalign_of(input logic [1:0] sz, input logic [1:0] lane);
        misalign_of = ((sz == 2'b01) && lane[0]) || ((sz == 2'b10) && (lane != 2'b00));
    endfunction

    // Low address bits forced to the natural alignment of the access size.
    function automatic logic [1:0] align_lane(input logic [1:0] sz, input logic [1:0] lane);
        case (sz)
            2'b00:   align_lane = lane;
            2'b01:   align_lane = {lane[1], 1'b0};
            default: align_lane = 2'b00;
        endcase
    endfunction

    // Shift the addressed lane down and sign- or zero-extend per funct3.
    function automatic logic [31:0] format_load(input logic [2:0] f3, input logic [1:0] lane,
                                                input logic [31:0] raw);
        logic [31:0]        sh;
        logic signed [7:0]  b_s;
        logic signed [15:0] h_s;
        sh  = raw >> {lane, 3'b000};
        b_s = signed'(sh[7:0]);
        h_s = signed'(sh[15:0]);
        case (f3)
            3'b000:  format_load = 32'(b_s);
            3'b001:  format_load = 32'(h_s);
            3'b100:  format_load = {24'd0, sh[7:0]};
            3'b101:  format_load = {16'd0, sh[15:0]};
            default: format_load = sh;
        endcase
    endfunction

    // Request decode and the combinational BRAM port for the start cycle.
    always_comb begin
        req_mmio   = (addr[31:16] == MMIO_HI);
        req_store  = op_store;
        req_load   = op_load & ~op_store;
        req_trap   = TRAP_EN & misalign_of(funct3[1:0], addr[1:0]);
        addr_eff   = {addr[31:2], align_lane(funct3[1:0], addr[1:0])};
        tmo_nxt    = tmo_cnt + CNT_W'(1);
        bram_go    = mem_start && (state == S_IDLE) && (req_store || req_load)
                     && !req_mmio && !req_trap;
        bram_addr  = bram_go ? addr_eff[ADDR_W+1:2] : waddr_p0;
        bram_we    = 4'b0000;
        bram_wdata = 32'd0;
        if (bram_go && req_store) begin
            bram_we    = byte_en(funct3[1:0], addr_eff[1:0]);
            bram_wdata = replicate(funct3[1:0], store_data);
        end
    end

    // Access sequencer: captures the request, runs BRAM read or MMIO handshake.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= S_IDLE;
            waddr_p0   <= '0;
            lane_p0    <= 2'b00;
            funct3_p0  <= 3'b000;
            load_p0    <= 1'b0;
            tmo_cnt    <= '0;
            mmio_valid <= 1'b0;
            mmio_we    <= 1'b0;
            mmio_addr  <= 32'd0;
            mmio_wdata <= 32'd0;
            load_data  <= 32'd0;
            mem_busy   <= 1'b0;
            misaligned <= 1'b0;
            bus_err    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (mem_start) begin
                        misaligned <= 1'b0;
                        bus_err    <= 1'b0;
                        if (req_store || req_load) begin
                            waddr_p0  <= addr_eff[ADDR_W+1:2];
                            lane_p0   <= addr_eff[1:0];
                            funct3_p0 <= funct3;
                            load_p0   <= req_load;
                            if (req_trap) begin
                                misaligned <= 1'b1;
                                load_data  <= 32'd0;
                                state      <= S_DONE;
                            end else if (req_mmio) begin
                                mmio_valid <= 1'b1;
                                mmio_we    <= req_store;
                                mmio_addr  <= addr_eff;
                                mmio_wdata <= replicate(funct3[1:0], store_data);
                                mem_busy   <= 1'b1;
                                tmo_cnt    <= '0;
                                state      <= S_MMIO_REQ;
                            end else if (req_load) begin
                                state <= S_BRAM_RD;
                            end else begin
                                state <= S_DONE;
                            end
                        end
                    end
                end
                S_BRAM_RD: begin
                    load_data <= format_load(funct3_p0, lane_p0, bram_rdata);
                    state     <= S_DONE;
                end
                S_MMIO_REQ: begin
                    tmo_cnt <= tmo_nxt;
                    if (mmio_ready) begin
                        mmio_valid <= 1'b0;
                        mem_busy   <= 1'b0;
                        if (load_p0) begin
                            load_data <= format_load(funct3_p0, lane_p0, mmio_rdata);
                        end
                        state <= S_DONE;
                    end else if (tmo_nxt == TIMEOUT_LIM) begin
                        bus_err    <= 1'b1;
                        load_data  <= 32'd0;
                        mmio_valid <= 1'b0;
                        mem_busy   <= 1'b0;
                        state      <= S_DONE;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed self-checking bench for mem_access_unit.
// Includes a small behavioural BRAM; MMIO responses are driven by the tasks.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        mem_start;
    logic        op_load;
    logic        op_store;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] store_data;
    logic [14:0] bram_addr;
    logic [3:0]  bram_we;
    logic [31:0] bram_wdata;
    logic [31:0] bram_rdata;
    logic        mmio_valid;
    logic        mmio_we;
    logic [31:0] mmio_addr;
    logic [31:0] mmio_wdata;
    logic        mmio_ready;
    logic [31:0] mmio_rdata;
    logic [31:0] load_data;
    logic        mem_busy;
    logic        misaligned;
    logic        bus_err;

    int checks = 0;
    int errors = 0;

    logic [31:0] mem [0:255];

    always #5 clk = ~clk;

    mem_access_unit dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .mem_start  (mem_start),
        .op_load    (op_load),
        .op_store   (op_store),
        .funct3     (funct3),
        .addr       (addr),
        .store_data (store_data),
        .bram_addr  (bram_addr),
        .bram_we    (bram_we),
        .bram_wdata (bram_wdata),
        .bram_rdata (bram_rdata),
        .mmio_valid (mmio_valid),
        .mmio_we    (mmio_we),
        .mmio_addr  (mmio_addr),
        .mmio_wdata (mmio_wdata),
        .mmio_ready (mmio_ready),
        .mmio_rdata (mmio_rdata),
        .load_data  (load_data),
        .mem_busy   (mem_busy),
        .misaligned (misaligned),
        .bus_err    (bus_err)
    );

    // Behavioural BRAM: byte-enabled write, one-cycle registered read.
    always @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (bram_we[i]) mem[bram_addr[7:0]][8*i +: 8] <= bram_wdata[8*i +: 8];
        end
        bram_rdata <= mem[bram_addr[7:0]];
    end

    // Presents a request in the current (negedge-aligned) cycle with mem_start high.
    task automatic drive_start(input logic ld, input logic st, input logic [2:0] f3,
                               input logic [31:0] a, input logic [31:0] d);
        mem_start  = 1'b1;
        op_load    = ld;
        op_store   = st;
        funct3     = f3;
        addr       = a;
        store_data = d;
        #1;
    endtask

    task automatic next_cycle();
        @(negedge clk);
        mem_start = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; mem_start = 1'b0; op_load = 1'b0; op_store = 1'b0;
        funct3 = 3'b000; addr = 32'd0; store_data = 32'd0;
        mmio_ready = 1'b0; mmio_rdata = 32'd0;
        repeat (2) @(negedge clk);
        checks++; if (mmio_valid !== 1'b0) begin errors++; $display("FAIL reset_mmio_valid got %b exp 0", mmio_valid); end
        checks++; if (mem_busy !== 1'b0) begin errors++; $display("FAIL reset_mem_busy got %b exp 0", mem_busy); end
        checks++; if (load_data !== 32'd0) begin errors++; $display("FAIL reset_load_data got %h exp 0", load_data); end
        checks++; if (bram_we !== 4'b0000) begin errors++; $display("FAIL reset_bram_we got %b exp 0000", bram_we); end
        checks++; if ({misaligned, bus_err} !== 2'b00) begin errors++; $display("FAIL reset_flags got %b exp 00", {misaligned, bus_err}); end
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_word();
        drive_start(1'b0, 1'b1, 3'b010, 32'h0000_0100, 32'hDEAD_BEEF);
        checks++; if (bram_we !== 4'b1111) begin errors++; $display("FAIL sw_we got %b exp 1111", bram_we); end
        checks++; if (bram_wdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL sw_wdata got %h exp deadbeef", bram_wdata); end
        checks++; if (bram_addr !== 15'h0040) begin errors++; $display("FAIL sw_addr got %h exp 0040", bram_addr); end
        next_cycle();
        checks++; if (bram_we !== 4'b0000) begin errors++; $display("FAIL sw_we_after got %b exp 0000", bram_we); end
        next_cycle();
        drive_start(1'b1, 1'b0, 3'b010, 32'h0000_0100, 32'd0);
        checks++; if (bram_addr !== 15'h0040) begin errors++; $display("FAIL lw_addr got %h exp 0040", bram_addr); end
        next_cycle();
        checks++; if (mem_busy !== 1'b0) begin errors++; $display("FAIL lw_busy got %b exp 0", mem_busy); end
        next_cycle();
        checks++; if (load_data !== 32'hDEAD_BEEF) begin errors++; $display("FAIL lw_data got %h exp deadbeef", load_data); end
        next_cycle();
        // A start with neither op bit leaves load_data untouched.
        drive_start(1'b0, 1'b0, 3'b010, 32'h0000_0200, 32'd0);
        next_cycle();
        next_cycle();
        checks++; if (load_data !== 32'hDEAD_BEEF) begin errors++; $display("FAIL noop_hold got %h exp deadbeef", load_data); end
    endtask

    task automatic test_byte_half();
        drive_start(1'b0, 1'b1, 3'b000, 32'h0000_0103, 32'h0000_0080);
        checks++; if (bram_we !== 4'b1000) begin errors++; $display("FAIL sb_we got %b exp 1000", bram_we); end
        checks++; if (bram_wdata !== 32'h8080_8080) begin errors++; $display("FAIL sb_wdata got %h exp 80808080", bram_wdata); end
        next_cycle(); next_cycle();
        drive_start(1'b1, 1'b0, 3'b000, 32'h0000_0103, 32'd0);
        next_cycle(); next_cycle();
        checks++; if (load_data !== 32'hFFFF_FF80) begin errors++; $display("FAIL lb_data got %h exp ffffff80", load_data); end
        next_cycle();
        drive_start(1'b1, 1'b0, 3'b100, 32'h0000_0103, 32'd0);
        next_cycle(); next_cycle();
        checks++; if (load_data !== 32'h0000_0080) begin errors++; $display("FAIL lbu_data got %h exp 00000080", load_data); end
        next_cycle();
        drive_start(1'b1, 1'b0, 3'b001, 32'h0000_0102, 32'd0);
        next_cycle(); next_cycle();
        checks++; if (load_data !== 32'hFFFF_80AD) begin errors++; $display("FAIL lh_data got %h exp ffff80ad", load_data); end
        next_cycle();
        drive_start(1'b1, 1'b0, 3'b101, 32'h0000_0102, 32'd0);
        next_cycle(); next_cycle();
        checks++; if (load_data !== 32'h0000_80AD) begin errors++; $display("FAIL lhu_data got %h exp 000080ad", load_data); end
        next_cycle();
    endtask

    task automatic test_mmio_load();
        int busy_cnt;
        drive_start(1'b1, 1'b0, 3'b001, 32'h8000_0010, 32'd0);
        checks++; if (bram_we !== 4'b0000) begin errors++; $display("FAIL mmio_ld_bram_we got %b exp 0000", bram_we); end
        next_cycle();
        checks++; if (mmio_valid !== 1'b1 || mmio_we !== 1'b0) begin errors++; $display("FAIL mmio_ld_req got %b%b exp 10", mmio_valid, mmio_we); end
        checks++; if (mmio_addr !== 32'h8000_0010) begin errors++; $display("FAIL mmio_ld_addr got %h exp 80000010", mmio_addr); end
        busy_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            if (mem_busy) busy_cnt++;
            if (i == 5) begin
                mmio_ready = 1'b1;
                mmio_rdata = 32'h0000_F00D;
            end
            @(negedge clk);
        end
        mmio_ready = 1'b0;
        checks++; if (busy_cnt !== 6) begin errors++; $display("FAIL mmio_ld_busy_cycles got %0d exp 6", busy_cnt); end
        checks++; if (mem_busy !== 1'b0 || mmio_valid !== 1'b0) begin errors++; $display("FAIL mmio_ld_release got %b%b exp 00", mem_busy, mmio_valid); end
        checks++; if (load_data !== 32'hFFFF_F00D) begin errors++; $display("FAIL mmio_ld_data got %h exp fffff00d", load_data); end
        next_cycle();
    endtask

    task automatic test_mmio_timeout();
        int cycles;
        drive_start(1'b0, 1'b1, 3'b010, 32'h8000_0020, 32'h1234_5678);
        next_cycle();
        checks++; if (mmio_valid !== 1'b1 || mmio_we !== 1'b1) begin errors++; $display("FAIL mmio_st_req got %b%b exp 11", mmio_valid, mmio_we); end
        checks++; if (mmio_wdata !== 32'h1234_5678) begin errors++; $display("FAIL mmio_st_wdata got %h exp 12345678", mmio_wdata); end
        // A stray start while the request is outstanding must be ignored.
        drive_start(1'b0, 1'b1, 3'b010, 32'h0000_0200, 32'hAAAA_AAAA);
        checks++; if (bram_we !== 4'b0000) begin errors++; $display("FAIL stray_start_we got %b exp 0000", bram_we); end
        next_cycle();
        checks++; if (mmio_valid !== 1'b1 || mmio_addr !== 32'h8000_0020) begin errors++; $display("FAIL stray_start_req got %b %h exp 1 80000020", mmio_valid, mmio_addr); end
        cycles = 1;
        while (mem_busy && cycles < 400) begin
            @(negedge clk);
            cycles++;
        end
        checks++; if (cycles !== 255) begin errors++; $display("FAIL timeout_cycles got %0d exp 255", cycles); end
        checks++; if (bus_err !== 1'b1 || mmio_valid !== 1'b0) begin errors++; $display("FAIL timeout_flags got %b%b exp 10", bus_err, mmio_valid); end
        checks++; if (load_data !== 32'd0) begin errors++; $display("FAIL timeout_load_data got %h exp 0", load_data); end
        next_cycle();
        next_cycle();
        checks++; if (bus_err !== 1'b1) begin errors++; $display("FAIL bus_err_sticky got %b exp 1", bus_err); end
        drive_start(1'b0, 1'b0, 3'b000, 32'd0, 32'd0);
        next_cycle();
        checks++; if (bus_err !== 1'b0) begin errors++; $display("FAIL bus_err_clear got %b exp 0", bus_err); end
        next_cycle();
    endtask

    task automatic test_misalign();
`ifdef MEM_MISALIGN_TRAP_EN
        drive_start(1'b1, 1'b0, 3'b010, 32'h0000_0102, 32'd0);
        next_cycle();
        checks++; if (misaligned !== 1'b1) begin errors++; $display("FAIL trap_lw_flag got %b exp 1", misaligned); end
        checks++; if (load_data !== 32'd0) begin errors++; $display("FAIL trap_lw_data got %h exp 0", load_data); end
        next_cycle();
        drive_start(1'b0, 1'b1, 3'b010, 32'h0000_0101, 32'h5555_5555);
        checks++; if (bram_we !== 4'b0000) begin errors++; $display("FAIL trap_sw_we got %b exp 0000", bram_we); end
        next_cycle(); next_cycle();
        drive_start(1'b1, 1'b0, 3'b010, 32'h0000_0100, 32'd0);
        next_cycle();
        checks++; if (misaligned !== 1'b0) begin errors++; $display("FAIL trap_clear got %b exp 0", misaligned); end
        next_cycle(); next_cycle();
`else
        drive_start(1'b1, 1'b0, 3'b010, 32'h0000_0102, 32'd0);
        checks++; if (bram_addr !== 15'h0040) begin errors++; $display("FAIL mask_lw_addr got %h exp 0040", bram_addr); end
        next_cycle(); next_cycle();
        checks++; if (load_data !== 32'h80AD_BEEF) begin errors++; $display("FAIL mask_lw_data got %h exp 80adbeef", load_data); end
        checks++; if (misaligned !== 1'b0) begin errors++; $display("FAIL mask_lw_flag got %b exp 0", misaligned); end
        next_cycle();
        drive_start(1'b0, 1'b1, 3'b010, 32'h0000_0106, 32'hCAFE_F00D);
        checks++; if (bram_we !== 4'b1111 || bram_addr !== 15'h0041) begin errors++; $display("FAIL mask_sw got %b %h exp 1111 0041", bram_we, bram_addr); end
        next_cycle(); next_cycle();
`endif
    endtask

    task automatic test_reset_in_mmio();
        drive_start(1'b1, 1'b0, 3'b010, 32'h8000_0040, 32'd0);
        next_cycle();
        checks++; if (mmio_valid !== 1'b1) begin errors++; $display("FAIL rst_mmio_pre got %b exp 1", mmio_valid); end
        #2;
        reset_n = 1'b0;
        #1;
        checks++; if (mmio_valid !== 1'b0 || mem_busy !== 1'b0) begin errors++; $display("FAIL rst_mmio_async got %b%b exp 00", mmio_valid, mem_busy); end
        checks++; if (load_data !== 32'd0) begin errors++; $display("FAIL rst_mmio_load_data got %h exp 0", load_data); end
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        drive_start(1'b1, 1'b0, 3'b010, 32'h0000_0100, 32'd0);
        next_cycle();
        checks++; if (mem_busy !== 1'b0) begin errors++; $display("FAIL rst_after_busy got %b exp 0", mem_busy); end
        next_cycle();
        checks++; if (load_data !== 32'h80AD_BEEF) begin errors++; $display("FAIL rst_after_lw got %h exp 80adbeef", load_data); end
        next_cycle();
    endtask

    initial begin
        test_reset();
        test_word();
        test_byte_half();
        test_mmio_load();
        test_mmio_timeout();
        test_misalign();
        test_reset_in_mmio();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired before the sequence completed");
        $fatal(1);
    end

endmodule
